control_unit: RTL and testbench

//  Hardwired Mini-SRC control sequencer; sits directly upstream of datapath, driving its read/write/select strobes.

---
 rtl/control_unit_pkg.sv | 50 +++++
 rtl/control_unit_instr_decode.sv | 53 +++++
 rtl/control_unit.sv | 261 ++++++++++++++++++++++++++
 tb/tb_control_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared Mini-SRC definitions: IR field positions, opcodes, ALU codes, sequencer states and instruction classes.
package control_unit_pkg;

  localparam int IR_W   = 32;
  localparam int OP_LSB = 27;
  localparam int RA_LSB = 23;
  localparam int RB_LSB = 19;
  localparam int RC_LSB = 15;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_SHR = 4'h2;
  localparam logic [3:0] ALU_SHL = 4'h3;
  localparam logic [3:0] ALU_ROR = 4'h4;
  localparam logic [3:0] ALU_ROL = 4'h5;
  localparam logic [3:0] ALU_AND = 4'h6;
  localparam logic [3:0] ALU_OR  = 4'h7;
  localparam logic [3:0] ALU_MUL = 4'h8;
  localparam logic [3:0] ALU_DIV = 4'h9;
  localparam logic [3:0] ALU_NEG = 4'hA;
  localparam logic [3:0] ALU_NOT = 4'hB;

  typedef enum logic [3:0] {
    S_CLR, S_F0, S_F1, S_F2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_ALU3, C_UNARY, C_MULDIV, C_MFHI, C_MFLO, C_LD, C_ST, C_NOP, C_HALT, C_ILLEGAL
  } iclass_t;

endpackage

// File: rtl/control_unit_instr_decode.sv
// Combinational instruction decode: opcode -> instruction class and ALU operation, plus Ra/Rb/Rc extraction.
module control_unit_instr_decode
  import control_unit_pkg::*;
#(
  parameter int OP_W      = 5,
  parameter int REG_SEL_W = 4,
  parameter int ALU_OP_W  = 4
) (
  input  logic [IR_W-1:0]      ir,
  output iclass_t              iclass,
  output logic [REG_SEL_W-1:0] ra,
  output logic [REG_SEL_W-1:0] rb,
  output logic [REG_SEL_W-1:0] rc,
  output logic [ALU_OP_W-1:0]  alu_op
);

  logic [OP_W-1:0] opcode;
  logic            unused_ir;

  assign opcode    = ir[OP_LSB +: OP_W];
  assign ra        = ir[RA_LSB +: REG_SEL_W];
  assign rb        = ir[RB_LSB +: REG_SEL_W];
  assign rc        = ir[RC_LSB +: REG_SEL_W];
  // Constant/immediate field is consumed by the datapath, not the sequencer.
  assign unused_ir = ^ir[RC_LSB-1:0];

  always_comb begin
    iclass = C_ILLEGAL;
    alu_op = '0;
    case (opcode)
      OP_LD:   iclass = C_LD;
      OP_ST:   iclass = C_ST;
      OP_ADD:  begin iclass = C_ALU3;   alu_op = ALU_ADD; end
      OP_SUB:  begin iclass = C_ALU3;   alu_op = ALU_SUB; end
      OP_SHR:  begin iclass = C_ALU3;   alu_op = ALU_SHR; end
      OP_SHL:  begin iclass = C_ALU3;   alu_op = ALU_SHL; end
      OP_ROR:  begin iclass = C_ALU3;   alu_op = ALU_ROR; end
      OP_ROL:  begin iclass = C_ALU3;   alu_op = ALU_ROL; end
      OP_AND:  begin iclass = C_ALU3;   alu_op = ALU_AND; end
      OP_OR:   begin iclass = C_ALU3;   alu_op = ALU_OR;  end
      OP_MUL:  begin iclass = C_MULDIV; alu_op = ALU_MUL; end
      OP_DIV:  begin iclass = C_MULDIV; alu_op = ALU_DIV; end
      OP_NEG:  begin iclass = C_UNARY;  alu_op = ALU_NEG; end
      OP_NOT:  begin iclass = C_UNARY;  alu_op = ALU_NOT; end
      OP_MFHI: iclass = C_MFHI;
      OP_MFLO: iclass = C_MFLO;
      OP_NOP:  iclass = C_NOP;
      OP_HALT: iclass = C_HALT;
      default: iclass = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Mini-SRC control sequencer (fetch, decode, execute T3..T7, memory handshake).
// Optional feature: define CU_SINGLE_STEP_EN to gate each instruction fetch on an in_step pulse.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int OP_W      = 5,
  parameter int REG_SEL_W = 4,
  parameter int ALU_OP_W  = 4
) (
  input  logic                 clk,
  input  logic                 in_clr,
  input  logic [IR_W-1:0]      in_ir,
  input  logic                 in_mem_ready,
  input  logic                 in_step,
  output logic [REG_SEL_W-1:0] out_regfile_location,
  output logic [ALU_OP_W-1:0]  out_alu_opcode,
  output logic                 out_reg_clear,
  output logic                 out_mdr_select,
  output logic                 out_inc_pc,
  output logic                 out_regfile_read,
  output logic                 out_hi_read,
  output logic                 out_lo_read,
  output logic                 out_z_hi_read,
  output logic                 out_z_lo_read,
  output logic                 out_pc_read,
  output logic                 out_mdr_read,
  output logic                 out_c_read,
  output logic                 out_regfile_write,
  output logic                 out_hi_write,
  output logic                 out_lo_write,
  output logic                 out_z_write,
  output logic                 out_pc_write,
  output logic                 out_mdr_write,
  output logic                 out_ir_write,
  output logic                 out_y_write,
  output logic                 out_mar_write,
  output logic                 out_mem_read,
  output logic                 out_mem_write,
  output logic                 out_instr_done,
  output logic                 out_halted,
  output logic                 out_illegal
);

  state_t               state;
  logic                 halted;
  logic                 illegal;
  iclass_t              iclass;
  logic [REG_SEL_W-1:0] ra, rb, rc;
  logic [ALU_OP_W-1:0]  alu_op;
  logic                 fetch_go;
  logic                 mem_stall;

  control_unit_instr_decode #(
    .OP_W      (OP_W),
    .REG_SEL_W (REG_SEL_W),
    .ALU_OP_W  (ALU_OP_W)
  ) u_decode (
    .ir     (in_ir),
    .iclass (iclass),
    .ra     (ra),
    .rb     (rb),
    .rc     (rc),
    .alu_op (alu_op)
  );

`ifdef CU_SINGLE_STEP_EN
  assign fetch_go = in_step;
`else
  logic unused_step;
  assign fetch_go    = 1'b1;
  assign unused_step = in_step;
`endif

  // Only the ld data read (T6) and st write (T7) wait on memory inside execute.
  assign mem_stall = !in_mem_ready &&
                     ((state == S_T6 && iclass == C_LD) || (state == S_T7 && iclass == C_ST));

  function automatic state_t next_step(input state_t s);
    case (s)
      S_T3:    return S_T4;
      S_T4:    return S_T5;
      S_T5:    return S_T6;
      S_T6:    return S_T7;
      default: return S_F0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (in_clr) begin
      state   <= S_CLR;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_CLR: state <= S_F0;
        S_F0:  if (fetch_go) state <= S_F1;
        S_F1:  if (in_mem_ready) state <= S_F2;
        S_F2:  state <= S_T3;
        S_T3, S_T4, S_T5, S_T6, S_T7: begin
          if (out_instr_done) begin
            state <= S_F0;
          end else if (state == S_T3 && (iclass == C_HALT || iclass == C_ILLEGAL)) begin
            state   <= S_HALT;
            halted  <= 1'b1;
            illegal <= (iclass == C_ILLEGAL);
          end else if (!mem_stall) begin
            state <= next_step(state);
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_CLR;
      endcase
    end
  end

  assign out_halted  = halted;
  assign out_illegal = illegal;

  always_comb begin
    out_regfile_location = '0;
    out_alu_opcode       = '0;
    out_reg_clear        = 1'b0;
    out_mdr_select       = 1'b0;
    out_inc_pc           = 1'b0;
    out_regfile_read     = 1'b0;
    out_hi_read          = 1'b0;
    out_lo_read          = 1'b0;
    out_z_hi_read        = 1'b0;
    out_z_lo_read        = 1'b0;
    out_pc_read          = 1'b0;
    out_mdr_read         = 1'b0;
    out_c_read           = 1'b0;
    out_regfile_write    = 1'b0;
    out_hi_write         = 1'b0;
    out_lo_write         = 1'b0;
    out_z_write          = 1'b0;
    out_pc_write         = 1'b0;
    out_mdr_write        = 1'b0;
    out_ir_write         = 1'b0;
    out_y_write          = 1'b0;
    out_mar_write        = 1'b0;
    out_mem_read         = 1'b0;
    out_mem_write        = 1'b0;
    out_instr_done       = 1'b0;
    case (state)
      S_CLR: out_reg_clear = 1'b1;
      S_F0: if (fetch_go) begin
        out_pc_read   = 1'b1;
        out_mar_write = 1'b1;
        out_inc_pc    = 1'b1;
        out_pc_write  = 1'b1;
      end
      S_F1: begin
        out_mem_read   = 1'b1;
        out_mdr_select = 1'b1;
        out_mdr_write  = in_mem_ready;
      end
      S_F2: begin
        out_mdr_read = 1'b1;
        out_ir_write = 1'b1;
      end
      S_T3: case (iclass)
        C_ALU3, C_LD, C_ST: begin
          out_regfile_location = rb;
          out_regfile_read     = 1'b1;
          out_y_write          = 1'b1;
        end
        C_UNARY: begin
          out_regfile_location = rb;
          out_regfile_read     = 1'b1;
          out_alu_opcode       = alu_op;
          out_z_write          = 1'b1;
        end
        C_MULDIV: begin
          out_regfile_location = ra;
          out_regfile_read     = 1'b1;
          out_y_write          = 1'b1;
        end
        C_MFHI, C_MFLO: begin
          out_hi_read          = (iclass == C_MFHI);
          out_lo_read          = (iclass == C_MFLO);
          out_regfile_location = ra;
          out_regfile_write    = 1'b1;
          out_instr_done       = 1'b1;
        end
        C_NOP:   out_instr_done = 1'b1;
        default: ;
      endcase
      S_T4: case (iclass)
        C_ALU3, C_MULDIV: begin
          out_regfile_location = (iclass == C_ALU3) ? rc : rb;
          out_regfile_read     = 1'b1;
          out_alu_opcode       = alu_op;
          out_z_write          = 1'b1;
        end
        C_UNARY: begin
          out_z_lo_read        = 1'b1;
          out_regfile_location = ra;
          out_regfile_write    = 1'b1;
          out_instr_done       = 1'b1;
        end
        C_LD, C_ST: begin
          out_c_read     = 1'b1;
          out_alu_opcode = ALU_ADD;
          out_z_write    = 1'b1;
        end
        default: ;
      endcase
      S_T5: case (iclass)
        C_ALU3: begin
          out_z_lo_read        = 1'b1;
          out_regfile_location = ra;
          out_regfile_write    = 1'b1;
          out_instr_done       = 1'b1;
        end
        C_MULDIV: begin
          out_z_lo_read = 1'b1;
          out_lo_write  = 1'b1;
        end
        C_LD, C_ST: begin
          out_z_lo_read = 1'b1;
          out_mar_write = 1'b1;
        end
        default: ;
      endcase
      S_T6: case (iclass)
        C_MULDIV: begin
          out_z_hi_read  = 1'b1;
          out_hi_write   = 1'b1;
          out_instr_done = 1'b1;
        end
        C_LD: begin
          out_mem_read   = 1'b1;
          out_mdr_select = 1'b1;
          out_mdr_write  = in_mem_ready;
        end
        C_ST: begin
          out_regfile_location = ra;
          out_regfile_read     = 1'b1;
          out_mdr_write        = 1'b1;
        end
        default: ;
      endcase
      S_T7: case (iclass)
        C_LD: begin
          out_mdr_read         = 1'b1;
          out_regfile_location = ra;
          out_regfile_write    = 1'b1;
          out_instr_done       = 1'b1;
        end
        C_ST: begin
          out_mem_write  = 1'b1;
          out_instr_done = in_mem_ready;
        end
        default: ;
      endcase
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-cycle strobe vectors compared against an instruction-level step model.
module tb_control_unit;

  typedef struct packed {
    logic [3:0] loc;
    logic [3:0] alu;
    logic reg_clear, mdr_select, inc_pc;
    logic rf_r, hi_r, lo_r, zhi_r, zlo_r, pc_r, mdr_r, c_r;
    logic rf_w, hi_w, lo_w, z_w, pc_w, mdr_w, ir_w, y_w, mar_w;
    logic mem_r, mem_w, done, halted, illegal;
  } outs_t;

  typedef struct {
    outs_t o;
    bit    wait_rd;
    bit    wait_wr;
  } step_t;

  logic        clk = 1'b0;
  logic        in_clr = 1'b0;
  logic [31:0] in_ir = '0;
  logic        in_mem_ready = 1'b0;
  logic        in_step = 1'b0;
  logic [3:0]  out_regfile_location, out_alu_opcode;
  logic out_reg_clear, out_mdr_select, out_inc_pc;
  logic out_regfile_read, out_hi_read, out_lo_read, out_z_hi_read, out_z_lo_read;
  logic out_pc_read, out_mdr_read, out_c_read;
  logic out_regfile_write, out_hi_write, out_lo_write, out_z_write, out_pc_write;
  logic out_mdr_write, out_ir_write, out_y_write, out_mar_write;
  logic out_mem_read, out_mem_write, out_instr_done, out_halted, out_illegal;

  outs_t obs;
  step_t exp_q[$];
  int    ntests = 0;
  int    nfail = 0;
  int    rdy_mode = 0;   // 0: random waits, 1: ready always, 2: ready after 3 low cycles
  int    icount = 0;
  bit    exp_halt, exp_illegal;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .in_clr(in_clr), .in_ir(in_ir), .in_mem_ready(in_mem_ready), .in_step(in_step),
    .out_regfile_location(out_regfile_location), .out_alu_opcode(out_alu_opcode),
    .out_reg_clear(out_reg_clear), .out_mdr_select(out_mdr_select), .out_inc_pc(out_inc_pc),
    .out_regfile_read(out_regfile_read), .out_hi_read(out_hi_read), .out_lo_read(out_lo_read),
    .out_z_hi_read(out_z_hi_read), .out_z_lo_read(out_z_lo_read), .out_pc_read(out_pc_read),
    .out_mdr_read(out_mdr_read), .out_c_read(out_c_read),
    .out_regfile_write(out_regfile_write), .out_hi_write(out_hi_write), .out_lo_write(out_lo_write),
    .out_z_write(out_z_write), .out_pc_write(out_pc_write), .out_mdr_write(out_mdr_write),
    .out_ir_write(out_ir_write), .out_y_write(out_y_write), .out_mar_write(out_mar_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_instr_done(out_instr_done),
    .out_halted(out_halted), .out_illegal(out_illegal)
  );

  assign obs = {out_regfile_location, out_alu_opcode, out_reg_clear, out_mdr_select, out_inc_pc,
                out_regfile_read, out_hi_read, out_lo_read, out_z_hi_read, out_z_lo_read,
                out_pc_read, out_mdr_read, out_c_read,
                out_regfile_write, out_hi_write, out_lo_write, out_z_write, out_pc_write,
                out_mdr_write, out_ir_write, out_y_write, out_mar_write,
                out_mem_read, out_mem_write, out_instr_done, out_halted, out_illegal};

  task automatic check(input string tag, input outs_t e);
    ntests++;
    assert (obs === e) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  function automatic logic [3:0] alu_code(input logic [4:0] op);
    if (op >= 5'd3 && op <= 5'd10) return 4'(op - 5'd3);
    case (op)
      5'd14:   return 4'h8;
      5'd15:   return 4'h9;
      5'd16:   return 4'hA;
      5'd17:   return 4'hB;
      default: return 4'h0;
    endcase
  endfunction

  task automatic push(input outs_t o, input bit wr, input bit ww);
    step_t s;
    s.o = o; s.wait_rd = wr; s.wait_wr = ww;
    exp_q.push_back(s);
  endtask

  // Expected cycle-by-cycle strobes for one instruction, from the instruction set tables.
  task automatic build(input logic [31:0] ir);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    outs_t o;
    op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
    in_ir = ir;
    exp_halt = 0; exp_illegal = 0;
    exp_q.delete();
    o = '0; o.pc_r = 1; o.mar_w = 1; o.inc_pc = 1; o.pc_w = 1; push(o, 0, 0);
    o = '0; o.mem_r = 1; o.mdr_select = 1; push(o, 1, 0);
    o = '0; o.mdr_r = 1; o.ir_w = 1; push(o, 0, 0);
    if (op >= 5'd3 && op <= 5'd10) begin
      o = '0; o.loc = rb; o.rf_r = 1; o.y_w = 1; push(o, 0, 0);
      o = '0; o.loc = rc; o.rf_r = 1; o.alu = alu_code(op); o.z_w = 1; push(o, 0, 0);
      o = '0; o.zlo_r = 1; o.loc = ra; o.rf_w = 1; o.done = 1; push(o, 0, 0);
    end else if (op == 5'd16 || op == 5'd17) begin
      o = '0; o.loc = rb; o.rf_r = 1; o.alu = alu_code(op); o.z_w = 1; push(o, 0, 0);
      o = '0; o.zlo_r = 1; o.loc = ra; o.rf_w = 1; o.done = 1; push(o, 0, 0);
    end else if (op == 5'd14 || op == 5'd15) begin
      o = '0; o.loc = ra; o.rf_r = 1; o.y_w = 1; push(o, 0, 0);
      o = '0; o.loc = rb; o.rf_r = 1; o.alu = alu_code(op); o.z_w = 1; push(o, 0, 0);
      o = '0; o.zlo_r = 1; o.lo_w = 1; push(o, 0, 0);
      o = '0; o.zhi_r = 1; o.hi_w = 1; o.done = 1; push(o, 0, 0);
    end else if (op == 5'd23 || op == 5'd24) begin
      o = '0; o.hi_r = (op == 5'd23); o.lo_r = (op == 5'd24);
      o.loc = ra; o.rf_w = 1; o.done = 1; push(o, 0, 0);
    end else if (op == 5'd0 || op == 5'd2) begin
      o = '0; o.loc = rb; o.rf_r = 1; o.y_w = 1; push(o, 0, 0);
      o = '0; o.c_r = 1; o.z_w = 1; push(o, 0, 0);
      o = '0; o.zlo_r = 1; o.mar_w = 1; push(o, 0, 0);
      if (op == 5'd0) begin
        o = '0; o.mem_r = 1; o.mdr_select = 1; push(o, 1, 0);
        o = '0; o.mdr_r = 1; o.loc = ra; o.rf_w = 1; o.done = 1; push(o, 0, 0);
      end else begin
        o = '0; o.loc = ra; o.rf_r = 1; o.mdr_w = 1; push(o, 0, 0);
        o = '0; o.mem_w = 1; push(o, 0, 1);
      end
    end else if (op == 5'd25) begin
      o = '0; o.done = 1; push(o, 0, 0);
    end else begin
      o = '0; push(o, 0, 0);
      exp_halt = 1; exp_illegal = (op != 5'd26);
    end
  endtask

  // Plays the first `upto` modelled steps; called and returning at posedge+1.
  task automatic run_steps(input int upto);
    for (int i = 0; i < upto; i++) begin
      int  n;
      bit  w, fin;
      outs_t e;
      n = 0; fin = 0;
      w = exp_q[i].wait_rd | exp_q[i].wait_wr;
      while (!fin) begin
        if (rdy_mode == 1) in_mem_ready = 1'b1;
        else if (w && rdy_mode == 2) in_mem_ready = (n >= 3);
        else if (w) in_mem_ready = (n >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
        else in_mem_ready = 1'($urandom_range(0, 1));
`ifdef CU_SINGLE_STEP_EN
        in_step = 1'b1;
`else
        in_step = 1'($urandom_range(0, 1));
`endif
        #1;
        e = exp_q[i].o;
        if (exp_q[i].wait_rd) e.mdr_w = in_mem_ready;
        if (exp_q[i].wait_wr) e.done = in_mem_ready;
        check($sformatf("instr%0d_step%0d_cyc%0d", icount, i, n), e);
        fin = !w || in_mem_ready;
        @(posedge clk); #1;
        n++;
      end
    end
    icount++;
  endtask

  task automatic do_reset();
    outs_t e;
    in_clr = 1'b1;
    @(posedge clk); #1;
    in_clr = 1'b0;
    e = '0; e.reg_clear = 1;
    check("reset_clr_state", e);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    static logic [4:0] legal_ops[17] = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                         5'd10, 5'd14, 5'd15, 5'd16, 5'd17, 5'd23, 5'd24, 5'd25};
    outs_t e;
    do_reset();

    rdy_mode = 1;
    build(32'h19890000); run_steps(exp_q.size());   // add R3,R1,R2
    rdy_mode = 2;
    build(32'h00880000); run_steps(exp_q.size());   // ld R1,C(R1) with slow memory
    rdy_mode = 0;
    build(32'h71180000); run_steps(exp_q.size());   // mul R2,R3

    for (int k = 0; k < 40; k++) begin
      logic [31:0] ir;
      ir = {legal_ops[$urandom_range(0, 16)], 27'($urandom)};
      build(ir); run_steps(exp_q.size());
    end

    // Illegal opcode halts sticky until clear
    build(32'hD8000000); run_steps(exp_q.size());
    for (int c = 0; c < 20; c++) begin
      in_mem_ready = 1'($urandom_range(0, 1));
      in_step = 1'($urandom_range(0, 1));
      #1;
      e = '0; e.halted = exp_halt; e.illegal = exp_illegal;
      check($sformatf("illegal_hold_%0d", c), e);
      @(posedge clk); #1;
    end
    do_reset();

    // halt opcode: halted without illegal
    build(32'hD0000000); run_steps(exp_q.size());
    for (int c = 0; c < 3; c++) begin
      #1;
      e = '0; e.halted = exp_halt; e.illegal = exp_illegal;
      check($sformatf("halt_hold_%0d", c), e);
      @(posedge clk); #1;
    end
    do_reset();

    // Clear during st write wait abandons the request
    build(32'h11000000 | {5'd0, 4'd5, 4'd6, 19'd0});
    run_steps(exp_q.size() - 1);
    in_mem_ready = 1'b0; #1;
    check("st_t7_wait", exp_q[exp_q.size() - 1].o);
    in_clr = 1'b1;
    @(posedge clk); #1;
    in_clr = 1'b0; in_mem_ready = 1'b0;
    e = '0; e.reg_clear = 1;
    check("st_abort_clr", e);
    @(posedge clk); #1;
    build(32'hC8000000); run_steps(exp_q.size());   // nop after restart

`ifdef CU_SINGLE_STEP_EN
    begin
      int pcw, dn;
      in_step = 1'b0;
      do_reset();
      in_ir = 32'hC8000000;
      pcw = 0; dn = 0;
      for (int p = 0; p < 4; p++) begin
        for (int c = 0; c < 10; c++) begin
          in_step = (c == 0);
          in_mem_ready = 1'b1;
          #1;
          pcw += int'(out_pc_write);
          dn += int'(out_instr_done);
          @(posedge clk); #1;
        end
      end
      in_step = 1'b0;
      ntests++;
      assert (pcw === 4) else begin
        nfail++; $error("FAIL step_pc_write observed=%0d expected=%0d", pcw, 4);
      end
      ntests++;
      assert (dn === 4) else begin
        nfail++; $error("FAIL step_instr_done observed=%0d expected=%0d", dn, 4);
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
